// File: rtl/reg_wb_arbiter_pkg.sv
// Shared register-file codes and types for the writeback arbiter slice.
package reg_wb_arbiter_pkg;

  typedef logic [3:0] reg_addr_t;

  localparam reg_addr_t RegZero = 4'd0;
  localparam reg_addr_t RegPc   = 4'd15;
  localparam reg_addr_t RegT    = 4'd14;

  typedef enum logic [1:0] {GntNone, GntA, GntB} grant_e;

  // Zero and PC are never written through the writeback port.
  function automatic logic is_gpr(reg_addr_t r);
    return (r != RegZero) && (r != RegPc);
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Writeback sources, decode issue/read ports and register-file write outputs.
interface reg_wb_arbiter_if #(
  parameter int unsigned DATA_W = 16
);
  logic              AValid;
  logic [3:0]        AReg;
  logic [DATA_W-1:0] AData;
  logic              AReady;
  logic              BValid;
  logic [3:0]        BReg;
  logic [DATA_W-1:0] BData;
  logic              BReady;
  logic              IssueValid;
  logic [3:0]        IssueReg;
  logic              IssueReady;
  logic [3:0]        Rs;
  logic [3:0]        Rt;
  logic              RsBusy;
  logic              RtBusy;
  logic              RegWre;
  logic [3:0]        WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [15:0]       PendingMask;

  modport master (
    output AValid, AReg, AData, BValid, BReg, BData, IssueValid, IssueReg, Rs, Rt,
    input  AReady, BReady, IssueReady, RsBusy, RtBusy, RegWre, WriteReg, WriteData, PendingMask
  );

  modport slave (
    input  AValid, AReg, AData, BValid, BReg, BData, IssueValid, IssueReg, Rs, Rt,
    output AReady, BReady, IssueReady, RsBusy, RtBusy, RegWre, WriteReg, WriteData, PendingMask
  );
endinterface

// File: rtl/reg_wb_arbiter_scoreboard.sv
// Per-register pending scoreboard: set on issue, cleared by the committed write.
module reg_wb_arbiter_scoreboard
  import reg_wb_arbiter_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        IssueValid,
  input  reg_addr_t   IssueReg,
  output logic        IssueReady,
  input  logic        ClrEn,
  input  reg_addr_t   ClrReg,
  input  reg_addr_t   Rs,
  input  reg_addr_t   Rt,
  output logic        RsBusy,
  output logic        RtBusy,
  output logic [15:0] PendingMask
);

  logic [15:0] pending_q, pending_d;

  assign IssueReady  = !pending_q[IssueReg];
  assign RsBusy      = pending_q[Rs] && is_gpr(Rs);
  assign RtBusy      = pending_q[Rt] && is_gpr(Rt);
  assign PendingMask = pending_q;

  // Set is applied after clear so a new writer to the same register stays outstanding.
  always_comb begin
    pending_d = pending_q;
    if (ClrEn) pending_d[ClrReg] = 1'b0;
    if (IssueValid && IssueReady && is_gpr(IssueReg)) pending_d[IssueReg] = 1'b1;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Two-source writeback arbiter for the register-file write port, with a starvation
// guard for source B and a registered write stage.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 3,
  parameter int unsigned DATA_W   = 16
) (
  input logic             Clk,
  input logic             Rst,
  reg_wb_arbiter_if.slave bus
);

  localparam logic [3:0] WaitLim = 4'(WAIT_MAX);

  grant_e            gnt;
  logic              force_b;
  logic [3:0]        starve_q, starve_d;
  reg_addr_t         gnt_reg;
  logic [DATA_W-1:0] gnt_data;
  logic              wre_q, wre_d;
  reg_addr_t         wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  always_comb begin
    force_b = bus.BValid && (starve_q == WaitLim);
    gnt     = GntNone;
    if (bus.AValid && !force_b) gnt = GntA;
    else if (bus.BValid)        gnt = GntB;
  end

  assign bus.AReady = (gnt == GntA);
  assign bus.BReady = (gnt == GntB);

  always_comb begin
    starve_d = '0;
    if (bus.BValid && (gnt != GntB)) begin
      starve_d = (starve_q == WaitLim) ? starve_q : starve_q + 4'd1;
    end
  end

  // Zero/PC grants complete the handshake but never raise the write enable.
  always_comb begin
    gnt_reg  = bus.AReg;
    gnt_data = bus.AData;
    if (gnt == GntB) begin
      gnt_reg  = bus.BReg;
      gnt_data = bus.BData;
    end
    wre_d   = (gnt != GntNone) && is_gpr(gnt_reg);
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    if (gnt != GntNone) begin
      wreg_d  = gnt_reg;
      wdata_d = gnt_data;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      starve_q <= '0;
      wre_q    <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      starve_q <= starve_d;
      wre_q    <= wre_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.RegWre    = wre_q;
  assign bus.WriteReg  = wreg_q;
  assign bus.WriteData = wdata_q;

  reg_wb_arbiter_scoreboard u_scoreboard (
    .Clk         (Clk),
    .Rst         (Rst),
    .IssueValid  (bus.IssueValid),
    .IssueReg    (bus.IssueReg),
    .IssueReady  (bus.IssueReady),
    .ClrEn       (wre_q),
    .ClrReg      (wreg_q),
    .Rs          (bus.Rs),
    .Rt          (bus.Rt),
    .RsBusy      (bus.RsBusy),
    .RtBusy      (bus.RtBusy),
    .PendingMask (bus.PendingMask)
  );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed and randomized checks of reg_wb_arbiter against a behavioural model.
module tb_reg_wb_arbiter;
  import reg_wb_arbiter_pkg::*;

  localparam int unsigned WaitMax = 3;
  localparam int unsigned DataW   = 16;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  reg_wb_arbiter_if #(.DATA_W(DataW)) bus ();

  reg_wb_arbiter #(.WAIT_MAX(WaitMax), .DATA_W(DataW)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: pending set, B refusal streak, expected write stage.
  bit          pend[16];
  int unsigned refused;
  bit          m_wre;
  logic [3:0]  m_wreg;
  logic [15:0] m_wdata;
  bit          last_a, last_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit special(input logic [3:0] r);
    return (r == RegZero) || (r == RegPc);
  endfunction

  function automatic logic [15:0] model_mask();
    logic [15:0] m;
    for (int i = 0; i < 16; i++) m[i] = pend[i];
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) pend[i] = 1'b0;
    refused = 0;
    m_wre   = 1'b0;
    m_wreg  = '0;
    m_wdata = '0;
    last_a  = 1'b0;
    last_b  = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.AValid = 1'b0; bus.AReg = '0; bus.AData = '0;
    bus.BValid = 1'b0; bus.BReg = '0; bus.BData = '0;
    bus.IssueValid = 1'b0; bus.IssueReg = '0;
    bus.Rs = '0; bus.Rt = '0;
  endtask

  // Entered at posedge+1 with inputs driven; leaves at the next posedge+1.
  task automatic cycle();
    bit forced, a_g, b_g, iss_ok;
    logic [3:0] w_reg;
    #3;
    forced = bus.BValid && (refused >= WaitMax);
    a_g    = bus.AValid && !forced;
    b_g    = bus.BValid && !a_g;
    iss_ok = !pend[bus.IssueReg];
    chk("AReady",      32'(bus.AReady),      32'(a_g));
    chk("BReady",      32'(bus.BReady),      32'(b_g));
    chk("IssueReady",  32'(bus.IssueReady),  32'(iss_ok));
    chk("RsBusy",      32'(bus.RsBusy),      32'(pend[bus.Rs] && !special(bus.Rs)));
    chk("RtBusy",      32'(bus.RtBusy),      32'(pend[bus.Rt] && !special(bus.Rt)));
    chk("RegWre",      32'(bus.RegWre),      32'(m_wre));
    chk("WriteReg",    32'(bus.WriteReg),    32'(m_wreg));
    chk("WriteData",   32'(bus.WriteData),   32'(m_wdata));
    chk("PendingMask", 32'(bus.PendingMask), 32'(model_mask()));
    @(posedge Clk);
    if (m_wre) pend[m_wreg] = 1'b0;
    if (bus.IssueValid && iss_ok && !special(bus.IssueReg)) pend[bus.IssueReg] = 1'b1;
    if (bus.BValid && !b_g) refused = (refused < WaitMax) ? refused + 1 : refused;
    else                    refused = 0;
    w_reg = a_g ? bus.AReg : bus.BReg;
    m_wre = (a_g || b_g) && !special(w_reg);
    if (a_g || b_g) begin
      m_wreg  = w_reg;
      m_wdata = a_g ? bus.AData : bus.BData;
    end
    last_a = a_g;
    last_b = b_g;
    #1;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    #1;
    chk("rst_wre",  32'(bus.RegWre),      32'd0);
    chk("rst_wreg", 32'(bus.WriteReg),    32'd0);
    chk("rst_wdat", 32'(bus.WriteData),   32'd0);
    chk("rst_mask", 32'(bus.PendingMask), 32'd0);
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;

    // A-only write.
    bus.AValid = 1'b1; bus.AReg = 4'd3; bus.AData = 16'h1234;
    cycle();
    chk("aonly_grant", 32'(last_a),        32'd1);
    chk("aonly_wre",   32'(bus.RegWre),    32'd1);
    chk("aonly_wreg",  32'(bus.WriteReg),  32'd3);
    chk("aonly_wdat",  32'(bus.WriteData), 32'h1234);
    bus.AValid = 1'b0;
    cycle();
    chk("aonly_wre_off", 32'(bus.RegWre), 32'd0);

    // Contention: A re-presented every cycle, B held until served.
    bus.AValid = 1'b1; bus.AReg = 4'd1; bus.AData = 16'h0a0a;
    bus.BValid = 1'b1; bus.BReg = 4'd2; bus.BData = 16'hb0b0;
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("cont_a_wins", 32'(last_a), 32'(k != 3));
      chk("cont_b_wins", 32'(last_b), 32'(k == 3));
      bus.AData = 16'(bus.AData + 16'd1);
      if (last_b) bus.BValid = 1'b0;
    end
    bus.AValid = 1'b0;
    cycle();

    // Scoreboard set, busy lookup, issue block, clear on B writeback.
    bus.IssueValid = 1'b1; bus.IssueReg = 4'd5;
    cycle();
    chk("sb_mask_set", 32'(bus.PendingMask), 32'h0020);
    bus.Rs = 4'd5;
    #1;
    chk("sb_rs_busy",    32'(bus.RsBusy),     32'd1);
    chk("sb_issue_blk",  32'(bus.IssueReady), 32'd0);
    cycle();
    bus.IssueValid = 1'b0;
    bus.BValid = 1'b1; bus.BReg = 4'd5; bus.BData = 16'h5555;
    cycle();
    bus.BValid = 1'b0;
    chk("sb_b_wre",      32'(bus.RegWre),      32'd1);
    chk("sb_mask_hold",  32'(bus.PendingMask), 32'h0020);
    cycle();
    chk("sb_mask_clr",   32'(bus.PendingMask), 32'h0000);

    // Same-posedge set and clear of register 7.
    bus.AValid = 1'b1; bus.AReg = 4'd7; bus.AData = 16'h7777;
    cycle();
    bus.AValid = 1'b0;
    bus.IssueValid = 1'b1; bus.IssueReg = 4'd7;
    cycle();
    bus.IssueValid = 1'b0;
    chk("same_edge_set", 32'(bus.PendingMask), 32'h0080);

    // Zero-register destination.
    bus.AValid = 1'b1; bus.AReg = RegZero; bus.AData = 16'hdead;
    bus.IssueValid = 1'b1; bus.IssueReg = RegZero; bus.Rs = RegZero;
    #1;
    chk("zero_aready", 32'(bus.AReady), 32'd1);
    chk("zero_rsbusy", 32'(bus.RsBusy), 32'd0);
    cycle();
    bus.AValid = 1'b0; bus.IssueValid = 1'b0;
    chk("zero_wre",  32'(bus.RegWre),      32'd0);
    chk("zero_mask", 32'(bus.PendingMask), 32'h0080);

    // Retire register 7, then build mask 0x0028 and reset mid-transfer.
    bus.AValid = 1'b1; bus.AReg = 4'd7;
    cycle();
    bus.AValid = 1'b0;
    cycle();
    bus.IssueValid = 1'b1; bus.IssueReg = 4'd3;
    cycle();
    bus.IssueReg = 4'd5;
    cycle();
    bus.IssueValid = 1'b0;
    bus.AValid = 1'b1; bus.AReg = 4'd9; bus.AData = 16'h9999;
    cycle();
    chk("pre_rst_mask", 32'(bus.PendingMask), 32'h0028);
    #2;
    Rst = 1'b1;
    #1;
    chk("mid_rst_wre",  32'(bus.RegWre),      32'd0);
    chk("mid_rst_wreg", 32'(bus.WriteReg),    32'd0);
    chk("mid_rst_wdat", 32'(bus.WriteData),   32'd0);
    chk("mid_rst_mask", 32'(bus.PendingMask), 32'd0);
    idle_inputs();
    model_reset();
    @(posedge Clk);
    #1;
    Rst = 1'b0;

    // Randomized traffic obeying the hold-until-granted rule.
    for (int n = 0; n < 400; n++) begin
      if (!(bus.AValid && !last_a)) begin
        bus.AValid = 1'($urandom_range(0, 1));
        bus.AReg   = 4'($urandom_range(0, 15));
        bus.AData  = 16'($urandom);
      end
      if (!(bus.BValid && !last_b)) begin
        bus.BValid = 1'($urandom_range(0, 1));
        bus.BReg   = 4'($urandom_range(0, 15));
        bus.BData  = 16'($urandom);
      end
      bus.IssueValid = 1'($urandom_range(0, 1));
      bus.IssueReg   = 4'($urandom_range(0, 15));
      bus.Rs         = 4'($urandom_range(0, 15));
      bus.Rt         = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
Sequences the single write port of the 16x16-bit register file, which has one port for two writeback sources.
- Source A is the ALU/EX result and has default priority.
- Source B is the load/MEM result and is protected by a starvation guard.
- A per-register pending scoreboard is fed from the decode-stage issue port and exposes busy flags for the current Rs/Rt, which decode uses for stalls.
- The registered outputs drive RegWre/WriteReg/WriteData of the register file; the register file commits on the following negedge Clk.

Parameters:
WAIT_MAX, 3, consecutive cycles B may be refused while valid before B is forced to win (1..15).
DATA_W, 16, writeback data width.

Ports:
Clk  in  1  system clock, posedge-active for this block.
Rst  in  1  asynchronous reset, active-high.
AValid  in  1  source A has a write pending.
AReg  in  4  source A destination register.
AData  in  DATA_W  source A write data.
AReady  out  1  source A granted this cycle (combinational).
BValid  in  1  source B has a write pending.
BReg  in  4  source B destination register.
BData  in  DATA_W  source B write data.
BReady  out  1  source B granted this cycle (combinational).
IssueValid  in  1  decode issues an instruction that will write IssueReg.
IssueReg  in  4  destination of the issued instruction.
IssueReady  out  1  issue accepted (combinational).
Rs  in  4  decode read address 1.
Rt  in  4  decode read address 2.
RsBusy  out  1  Rs has an outstanding write (combinational).
RtBusy  out  1  Rt has an outstanding write (combinational).
RegWre  out  1  register-file write enable (registered).
WriteReg  out  4  register-file write address (registered).
WriteData  out  DATA_W  register-file write data (registered).
PendingMask  out  16  scoreboard bits, bit i = register i pending.

Behaviour:
- Reset (Rst=1, async): RegWre=0, WriteReg=0, WriteData=0, PendingMask=0, starvation counter=0. Reset mid-transfer drops any in-flight write; requesters re-present after reset.
- Transfers:
  - A transfer occurs when Valid&&Ready.
  - Requesters hold Reg/Data stable while Valid&&!Ready.
  - Valid must not drop before its transfer.
- Arbitration (combinational):
  - One grant at most per cycle.
  - Default: A wins if AValid; otherwise B wins if BValid.
  - Forced: if BValid and the counter equals WAIT_MAX, B wins and A is refused.
- Starvation counter:
  - Increments at posedge when BValid&&!BReady, saturating at WAIT_MAX.
  - Clears to 0 on a B grant or when BValid=0.
- Write output latency is 1 cycle: a grant in cycle N gives RegWre=1 with the winner's Reg/Data throughout cycle N+1. With no grant, RegWre=0 at the next posedge and WriteReg/WriteData hold their previous values.
- `REG0 destination:
  - The grant handshake completes normally.
  - RegWre stays 0 for that transfer.
  - The pending bit is never set or cleared for `REG0.
- `PC destination: treated like `REG0, because the PC register is not written through this port.
- `T destination: passed through unchanged; the zero-compare is performed by the register file.
- Scoreboard:
  - Set: at posedge when IssueValid&&IssueReady&&IssueReg not in {`REG0,`PC}.
  - Clear: at the posedge ending a cycle in which RegWre=1, for bit WriteReg.
  - Same register set and cleared at the same posedge: set wins, since the new writer is outstanding.
- IssueReady = !PendingMask[IssueReg]. This permits only one in-flight writer per register, which rules out WAW races.
- RsBusy = PendingMask[Rs]; RtBusy = PendingMask[Rt]. Both are forced to 0 when the address is `REG0 or `PC.
- A writeback to a register that is not pending is legal, with no scoreboard effect beyond a no-op clear.

Decomposition:
- Shared package (config.v): `REG0, `PC and `T register codes.
- Natural sub-module: wb_scoreboard, which holds the 16-bit pending vector, set/clear logic and busy lookups.
- The arbiter, starvation counter and output registers stay in the top module.

Test Plan:
- Reset behaviour: assert Rst mid-stream with PendingMask=16'h0028 -> outputs 0 and PendingMask=0 immediately, before the next posedge.
- A-only write: AValid, AReg=3, AData=16'h1234 -> AReady=1 in the same cycle; next cycle RegWre=1, WriteReg=3, WriteData=16'h1234; the following cycle RegWre=0.
- Contention: AValid and BValid held continuously (A re-presented every cycle), WAIT_MAX=3 -> A wins 3 cycles, B wins cycle 4, counter returns to 0, then A resumes.
- Scoreboard: issue reg 5 -> PendingMask=16'h0020, Rs=5 gives RsBusy=1, and a second issue to 5 has IssueReady=0. After B writes reg 5, the bit clears at the posedge after RegWre=1.
- Same-posedge set/clear: issue reg 7 in the same posedge where the RegWre=1/WriteReg=7 write clears it -> bit 7 remains 1.
- Zero-register write: AReg=`REG0 -> AReady=1 but RegWre stays 0; IssueReg=`REG0 leaves PendingMask unchanged; Rs=`REG0 gives RsBusy=0.
